// File: rtl/palette_out_pkg.sv
// palette_out_pkg: colour-field positions, write-port states and pipeline depth for palette_out.
package palette_out_pkg;
  localparam int PIPE_DEPTH = 2;
  localparam int R_LSB = 0;
  localparam int R_MSB = 2;
  localparam int G_LSB = 3;
  localparam int G_MSB = 5;
  localparam int B_LSB = 6;
  localparam int B_MSB = 7;
  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} wr_state_t;
endpackage

// File: rtl/palette_out_ram.sv
// palette_ram: 16x8 palette, synchronous write with full clear on reset, asynchronous read.
module palette_ram (
  input  logic       clk24,
  input  logic       reset,
  input  logic       we,
  input  logic [3:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_data
);
  logic [7:0] mem [16];
  always_ff @(posedge clk24)
    if (reset) for (int i = 0; i < 16; i++) mem[i] <= '0;
    else if (we) mem[wr_idx] <= wr_data;
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/palette_out.sv
// palette_out: buffered CPU palette writes plus a 2-stage colour lookup, blanking and DAC expansion.
module palette_out
  import palette_out_pkg::*;
#(
  parameter bit WR_ON_RETRACE = 0
) (
  input  logic       clk24,
  input  logic       reset,
  input  logic       ce12,
  input  logic [3:0] coloridx,
  input  logic       videoActive,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       retrace,
  input  logic       pal_wr,
  input  logic [3:0] pal_idx,
  input  logic [7:0] pal_data,
  output logic [7:0] realcolor,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hsync_o,
  output logic       vsync_o
);
  wr_state_t state, state_nx;
  logic [3:0] pend_idx, s1_idx;
  logic [7:0] pend_data, rd_data, color, blanked;
  logic commit, s1_act;
  logic [PIPE_DEPTH-1:0] hs_d, vs_d;
  always_comb begin
    commit = state == PENDING && ce12 && (!WR_ON_RETRACE || retrace);
    state_nx = pal_wr ? PENDING : commit ? IDLE : state;
    color = (commit && pend_idx == s1_idx) ? pend_data : rd_data;
    blanked = s1_act ? color : '0;
  end
  always_ff @(posedge clk24)
    if (reset) begin
      state <= IDLE;
      pend_idx <= '0;
      pend_data <= '0;
    end else begin
      state <= state_nx;
      if (pal_wr) begin
        pend_idx <= pal_idx;
        pend_data <= pal_data;
      end
    end
  palette_ram u_ram (
    .clk24(clk24),
    .reset(reset),
    .we(commit),
    .wr_idx(pend_idx),
    .wr_data(pend_data),
    .rd_idx(s1_idx),
    .rd_data(rd_data)
  );
  // Syncs ride a PIPE_DEPTH shift so they stay aligned with the colour path.
  always_ff @(posedge clk24)
    if (reset) begin
      s1_idx <= '0;
      s1_act <= 1'b0;
      hs_d <= '1;
      vs_d <= '1;
      realcolor <= '0;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      s1_idx <= coloridx;
      s1_act <= videoActive;
      hs_d <= {hs_d[PIPE_DEPTH-2:0], hsync};
      vs_d <= {vs_d[PIPE_DEPTH-2:0], vsync};
      realcolor <= blanked;
      vga_r <= {blanked[R_MSB:R_LSB], blanked[R_MSB]};
      vga_g <= {blanked[G_MSB:G_LSB], blanked[G_MSB]};
      vga_b <= {2{blanked[B_MSB:B_LSB]}};
    end
  assign hsync_o = hs_d[PIPE_DEPTH-1];
  assign vsync_o = vs_d[PIPE_DEPTH-1];
endmodule

// File: tb/tb_palette_out.sv
// tb_palette_out: directed checks of palette writes, lookup latency, bypass, blanking and retrace gating.
module tb_palette_out;
  logic clk24 = 0, reset = 1, ce12 = 0, videoActive = 0, hsync = 1, vsync = 1, retrace = 0, pal_wr = 0;
  logic [3:0] coloridx = 0, pal_idx = 0;
  logic [7:0] pal_data = 0;
  logic [7:0] rc0, rc1;
  logic [3:0] vr0, vg0, vb0, vr1, vg1, vb1;
  logic hs0, vs0, hs1, vs1;
  int checks = 0, errs = 0;

  always #5 clk24 = ~clk24;

  palette_out u0 (
    .clk24(clk24), .reset(reset), .ce12(ce12), .coloridx(coloridx), .videoActive(videoActive),
    .hsync(hsync), .vsync(vsync), .retrace(retrace), .pal_wr(pal_wr), .pal_idx(pal_idx),
    .pal_data(pal_data), .realcolor(rc0), .vga_r(vr0), .vga_g(vg0), .vga_b(vb0),
    .hsync_o(hs0), .vsync_o(vs0)
  );
  palette_out #(.WR_ON_RETRACE(1)) u1 (
    .clk24(clk24), .reset(reset), .ce12(ce12), .coloridx(coloridx), .videoActive(videoActive),
    .hsync(hsync), .vsync(vsync), .retrace(retrace), .pal_wr(pal_wr), .pal_idx(pal_idx),
    .pal_data(pal_data), .realcolor(rc1), .vga_r(vr1), .vga_g(vg1), .vga_b(vb1),
    .hsync_o(hs1), .vsync_o(vs1)
  );

  task automatic tick;
    @(posedge clk24);
    #1;
  endtask

  task automatic read_entry(input logic [3:0] i);
    coloridx = i;
    videoActive = 1;
    tick;
    tick;
  endtask

  task automatic test_reset;
    reset = 1; hsync = 0; vsync = 0; ce12 = 1;
    pal_wr = 1; pal_idx = 0; pal_data = 8'hAA;
    tick; tick;
    checks++;
    if ({rc0, vr0, vg0, vb0, hs0, vs0} !== {8'h00, 12'h000, 2'b11}) begin
      errs++;
      $display("FAIL reset_outputs: got rc=%h vga=%h%h%h hs=%b vs=%b want rc=00 vga=000 hs=1 vs=1", rc0, vr0, vg0, vb0, hs0, vs0);
    end
    reset = 0; pal_wr = 0; hsync = 1; vsync = 1;
    read_entry(5);
    checks++;
    if ({rc0, vr0, vg0, vb0} !== 20'h0) begin
      errs++;
      $display("FAIL reset_entry5: got rc=%h vga=%h%h%h want 00 000", rc0, vr0, vg0, vb0);
    end
    read_entry(0);
    checks++;
    if (rc0 !== 8'h00) begin
      errs++;
      $display("FAIL wr_during_reset: got %h want 00", rc0);
    end
    ce12 = 0;
  endtask

  task automatic test_write;
    pal_wr = 1; pal_idx = 3; pal_data = 8'hFF; tick;
    pal_wr = 0; ce12 = 1; tick;
    ce12 = 0;
    read_entry(3);
    checks++;
    if ({rc0, vr0, vg0, vb0} !== {8'hFF, 12'hFFF}) begin
      errs++;
      $display("FAIL write_ff: got rc=%h vga=%h%h%h want FF FFF", rc0, vr0, vg0, vb0);
    end
    pal_wr = 1; pal_idx = 4; pal_data = 8'h9D; tick;
    pal_wr = 0; ce12 = 1; tick;
    ce12 = 0;
    read_entry(4);
    checks++;
    if ({rc0, vr0, vg0, vb0} !== {8'h9D, 12'hB6A}) begin
      errs++;
      $display("FAIL expand_9d: got rc=%h vga=%h%h%h want 9D B6A", rc0, vr0, vg0, vb0);
    end
  endtask

  task automatic test_overwrite;
    coloridx = 7; videoActive = 1; ce12 = 0;
    pal_wr = 1; pal_idx = 7; pal_data = 8'h07; tick;
    pal_data = 8'hC0; tick;
    pal_wr = 0; ce12 = 1; tick;
    ce12 = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (rc0 === 8'h07) begin
        errs++;
        $display("FAIL overwrite_no07: got %h want not 07", rc0);
      end
    end
    checks++;
    if (rc0 !== 8'hC0) begin
      errs++;
      $display("FAIL overwrite_c0: got %h want C0", rc0);
    end
  endtask

  task automatic test_back_to_back;
    ce12 = 0;
    pal_wr = 1; pal_idx = 8; pal_data = 8'h11; tick;
    pal_idx = 9; pal_data = 8'h22; ce12 = 1; tick;
    pal_wr = 0; ce12 = 0;
    read_entry(8);
    checks++;
    if (rc0 !== 8'h11) begin
      errs++;
      $display("FAIL b2b_old_commit: got %h want 11", rc0);
    end
    read_entry(9);
    checks++;
    if (rc0 !== 8'h00) begin
      errs++;
      $display("FAIL b2b_still_pending: got %h want 00", rc0);
    end
    ce12 = 1; tick;
    ce12 = 0;
    read_entry(9);
    checks++;
    if (rc0 !== 8'h22) begin
      errs++;
      $display("FAIL b2b_new_commit: got %h want 22", rc0);
    end
  endtask

  task automatic test_bypass;
    ce12 = 0; coloridx = 2; videoActive = 1;
    pal_wr = 1; pal_idx = 2; pal_data = 8'h92; tick;
    pal_wr = 0; ce12 = 1; tick;
    ce12 = 0;
    checks++;
    if (rc0 !== 8'h92) begin
      errs++;
      $display("FAIL bypass: got %h want 92", rc0);
    end
  endtask

  task automatic test_sync;
    logic [2:0] pat [8];
    pat = '{3'b111, 3'b101, 3'b110, 3'b011, 3'b100, 3'b111, 3'b001, 3'b110};
    coloridx = 3; ce12 = 0;
    for (int i = 0; i < 8; i++) begin
      {videoActive, hsync, vsync} = pat[i];
      tick;
      if (i > 0) begin
        checks++;
        if ({rc0, hs0, vs0} !== {pat[i-1][2] ? 8'hFF : 8'h00, pat[i-1][1:0]}) begin
          errs++;
          $display("FAIL sync_lag_%0d: got rc=%h hs=%b vs=%b want va=%b hs=%b vs=%b", i, rc0, hs0, vs0, pat[i-1][2], pat[i-1][1], pat[i-1][0]);
        end
      end
    end
    hsync = 1; vsync = 1; videoActive = 1;
  endtask

  task automatic test_reset_pending;
    ce12 = 0;
    pal_wr = 1; pal_idx = 6; pal_data = 8'h5A; tick;
    pal_wr = 0; reset = 1; ce12 = 1; tick;
    reset = 0; tick; tick;
    read_entry(6);
    checks++;
    if (rc0 !== 8'h00) begin
      errs++;
      $display("FAIL reset_pending_discard: got %h want 00", rc0);
    end
    read_entry(3);
    checks++;
    if (rc0 !== 8'h00) begin
      errs++;
      $display("FAIL reset_clears_entry3: got %h want 00", rc0);
    end
    ce12 = 0;
  endtask

  task automatic test_retrace;
    retrace = 0; ce12 = 0;
    pal_wr = 1; pal_idx = 1; pal_data = 8'h38; tick;
    pal_wr = 0; ce12 = 1; tick; tick; tick;
    read_entry(1);
    checks++;
    if (rc1 !== 8'h00) begin
      errs++;
      $display("FAIL retrace_hold: got %h want 00", rc1);
    end
    checks++;
    if (rc0 !== 8'h38) begin
      errs++;
      $display("FAIL no_retrace_gate: got %h want 38", rc0);
    end
    retrace = 1; tick;
    retrace = 0;
    read_entry(1);
    checks++;
    if ({rc1, vr1, vg1, vb1} !== {8'h38, 12'h0F0}) begin
      errs++;
      $display("FAIL retrace_commit: got rc=%h vga=%h%h%h want 38 0F0", rc1, vr1, vg1, vb1);
    end
    ce12 = 0;
  endtask

  initial begin
    test_reset;
    test_write;
    test_overwrite;
    test_back_to_back;
    test_bypass;
    test_sync;
    test_reset_pending;
    test_retrace;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
